// File: rtl/prng_arbiter_pkg.sv
// Shared definitions for the PRNG arbiter: PCG constants, FSM states and
// the generator step/permutation helpers.
package prng_arbiter_pkg;

  localparam logic [15:0] PCG_MULT = 16'h5851;
  localparam logic [15:0] PCG_INC  = 16'h1405;

  typedef enum logic {
    WARMUP,
    SERVE
  } arb_state_t;

  function automatic logic [15:0] pcg_next(input logic [15:0] s);
    return s * PCG_MULT + PCG_INC;
  endfunction

  // Xorshift-fold the state, then rotate right by three state bits.
  function automatic logic [7:0] pcg_perm(input logic [15:0] s);
    logic [15:0] mixed;
    logic [7:0]  xs;
    logic [2:0]  rot;
    logic [15:0] dbl;
    mixed = (s ^ (s >> 1)) >> 3;
    xs    = mixed[7:0];
    rot   = s[5:3];
    dbl   = {xs, xs} >> rot;
    return dbl[7:0];
  endfunction

endpackage

// File: rtl/prng_arbiter_pcg16_core.sv
// 16-bit LCG state register with load and step controls; exposes the
// permuted output byte of the current state combinationally.
module pcg16_core
  import prng_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [7:0]  perm
);

  logic [15:0] s;

  // A load takes priority over a step in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= 16'h0000;
    end else if (load) begin
      s <= load_val;
    end else if (step) begin
      s <= pcg_next(s);
    end
  end

  assign perm = pcg_perm(s);

endmodule

// File: rtl/prng_arbiter.sv
// Round-robin arbiter handing out one pseudo-random byte per grant, with a
// warm-up phase that discards generator steps after reset or reseed.
module prng_arbiter
  import prng_arbiter_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int WARMUP_STEPS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            seed_valid,
  input  logic [15:0]     seed,
  output logic [NREQ-1:0] gnt,
  output logic [7:0]      rnd,
  output logic            busy
);

  localparam int              PTR_W       = $clog2(NREQ);
  localparam logic [3:0]      WARM_INIT   = 4'(WARMUP_STEPS);
  localparam arb_state_t      RESET_STATE = (WARMUP_STEPS == 0) ? SERVE : WARMUP;
  localparam logic [NREQ-1:0] ONE_HOT0    = NREQ'(1);

  arb_state_t       state, next_state;
  logic [3:0]       warm_cnt, warm_cnt_next;
  logic [PTR_W-1:0] ptr, sel_idx, cand;
  logic             sel_found;
  logic             core_step, core_load, do_grant;
  logic [7:0]       perm;
  logic [NREQ-1:0]  gnt_q;
  logic [7:0]       rnd_q;

  pcg16_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (core_step),
    .load     (core_load),
    .load_val (seed),
    .perm     (perm)
  );

  // Search starts one past the last granted requester and wraps.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr;
    cand      = ptr;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % NREQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RESET_STATE;
      warm_cnt <= WARM_INIT;
    end else begin
      state    <= next_state;
      warm_cnt <= warm_cnt_next;
    end
  end

  always_comb begin
    next_state    = state;
    warm_cnt_next = warm_cnt;
    core_step     = 1'b0;
    core_load     = 1'b0;
    do_grant      = 1'b0;
    if (seed_valid) begin
      core_load     = 1'b1;
      warm_cnt_next = WARM_INIT;
      next_state    = RESET_STATE;
    end else begin
      case (state)
        WARMUP: begin
          core_step = 1'b1;
          if (warm_cnt != 4'd0) warm_cnt_next = warm_cnt - 4'd1;
          if (warm_cnt <= 4'd1) next_state = SERVE;
        end
        SERVE: begin
          if (sel_found) begin
            do_grant  = 1'b1;
            core_step = 1'b1;
          end
        end
        default: next_state = RESET_STATE;
      endcase
    end
  end

  // Grant pulses for one cycle; the byte and pointer hold until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= PTR_W'(NREQ - 1);
      gnt_q <= '0;
      rnd_q <= 8'h00;
    end else begin
      gnt_q <= do_grant ? (ONE_HOT0 << sel_idx) : '0;
      if (do_grant) begin
        ptr   <= sel_idx;
        rnd_q <= perm;
      end
    end
  end

  assign gnt  = gnt_q;
  assign rnd  = rnd_q;
  assign busy = (state == WARMUP);

endmodule

// File: tb/tb_prng_arbiter.sv
// Self-checking bench: one instance without warm-up, one with the default
// warm-up, driven by directed scenarios and a randomized model comparison.
module tb_prng_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n0, seed_valid0, busy0;
  logic [N-1:0] req0, gnt0;
  logic [15:0]  seed0;
  logic [7:0]   rnd0;

  logic         rst_n4, seed_valid4, busy4;
  logic [N-1:0] req4, gnt4;
  logic [15:0]  seed4;
  logic [7:0]   rnd4;

  int n_checks = 0;
  int n_fail   = 0;

  prng_arbiter #(.NREQ(N), .WARMUP_STEPS(0)) dut0 (
    .clk(clk), .rst_n(rst_n0), .req(req0), .seed_valid(seed_valid0),
    .seed(seed0), .gnt(gnt0), .rnd(rnd0), .busy(busy0)
  );

  prng_arbiter #(.NREQ(N), .WARMUP_STEPS(4)) dut4 (
    .clk(clk), .rst_n(rst_n4), .req(req4), .seed_valid(seed_valid4),
    .seed(seed4), .gnt(gnt4), .rnd(rnd4), .busy(busy4)
  );

  // Reference arithmetic straight from the generator definition.
  function automatic int model_next(input int s);
    return (s * 22609 + 5125) % 65536;
  endfunction

  function automatic logic [7:0] model_perm(input int s);
    int xs, rot;
    xs  = ((s ^ (s / 2)) / 8) % 256;
    rot = (s / 8) % 8;
    return 8'(((xs >> rot) | (xs << (8 - rot))) % 256);
  endfunction

  function automatic int model_warm(input int s, input int steps);
    int v = s;
    for (int i = 0; i < steps; i++) v = model_next(v);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n0 = 1'b0; rst_n4 = 1'b0;
    req0 = '0; req4 = '0;
    seed_valid0 = 1'b0; seed_valid4 = 1'b0;
    seed0 = 16'h0; seed4 = 16'h0;
    repeat (2) tick();
    n_checks++; if (gnt0 !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_gnt0 got %b want 0000", gnt0); end
    n_checks++; if (rnd0 !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rnd0 got %h want 00", rnd0); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy0 got %b want 0", busy0); end
    n_checks++; if (gnt4 !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_gnt4 got %b want 0000", gnt4); end
    n_checks++; if (rnd4 !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rnd4 got %h want 00", rnd4); end
    n_checks++; if (busy4 !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_busy4 got %b want 1", busy4); end
  endtask

  task automatic test_no_warmup();
    logic [7:0] exp_r [3];
    exp_r[0] = 8'h00; exp_r[1] = 8'hC0; exp_r[2] = 8'h45;
    rst_n0 = 1'b1;
    req0   = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (gnt0 !== 4'b0001) begin n_fail++; $display("[TB] FAIL nowarm_gnt[%0d] got %b want 0001", i, gnt0); end
      n_checks++; if (rnd0 !== exp_r[i]) begin n_fail++; $display("[TB] FAIL nowarm_rnd[%0d] got %h want %h", i, rnd0, exp_r[i]); end
    end
    req0 = '0;
    tick();
    n_checks++; if (gnt0 !== 4'b0000) begin n_fail++; $display("[TB] FAIL nowarm_idle_gnt got %b want 0000", gnt0); end
    n_checks++; if (rnd0 !== 8'h45) begin n_fail++; $display("[TB] FAIL nowarm_hold_rnd got %h want 45", rnd0); end
  endtask

  task automatic test_seed();
    req0 = 4'b0010; seed_valid0 = 1'b1; seed0 = 16'h0000;
    tick();
    n_checks++; if (gnt0 !== 4'b0000) begin n_fail++; $display("[TB] FAIL seed_nogrant got %b want 0000", gnt0); end
    seed_valid0 = 1'b0;
    tick();
    n_checks++; if (gnt0 !== 4'b0010) begin n_fail++; $display("[TB] FAIL seed_gnt0 got %b want 0010", gnt0); end
    n_checks++; if (rnd0 !== 8'h00) begin n_fail++; $display("[TB] FAIL seed_rnd0 got %h want 00", rnd0); end
    tick();
    n_checks++; if (gnt0 !== 4'b0010) begin n_fail++; $display("[TB] FAIL seed_gnt1 got %b want 0010", gnt0); end
    n_checks++; if (rnd0 !== 8'hC0) begin n_fail++; $display("[TB] FAIL seed_rnd1 got %h want C0", rnd0); end
    req0 = '0;
    tick();
  endtask

  task automatic test_warmup_order();
    logic [N-1:0] exp_g;
    logic [7:0]   exp_r;
    rst_n4 = 1'b1;
    req4   = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (busy4 !== 1'b1) begin n_fail++; $display("[TB] FAIL warm_busy[%0d] got %b want 1", i, busy4); end
      n_checks++; if (gnt4 !== 4'b0000) begin n_fail++; $display("[TB] FAIL warm_gnt[%0d] got %b want 0000", i, gnt4); end
      tick();
    end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("[TB] FAIL warm_done_busy got %b want 0", busy4); end
    n_checks++; if (gnt4 !== 4'b0000) begin n_fail++; $display("[TB] FAIL warm_done_gnt got %b want 0000", gnt4); end
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_g = 4'b0001 << (i % 4);
      exp_r = model_perm(model_warm(0, 4 + i));
      n_checks++; if (gnt4 !== exp_g) begin n_fail++; $display("[TB] FAIL rr_order[%0d] got %b want %b", i, gnt4, exp_g); end
      n_checks++; if (rnd4 !== exp_r) begin n_fail++; $display("[TB] FAIL rr_rnd[%0d] got %h want %h", i, rnd4, exp_r); end
    end
    req4 = '0;
    tick();
  endtask

  task automatic test_alternate();
    logic [N-1:0] exp_g;
    req4 = 4'b1000;
    tick();
    n_checks++; if (gnt4 !== 4'b1000) begin n_fail++; $display("[TB] FAIL alt_prime got %b want 1000", gnt4); end
    req4 = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_g = (i % 2 == 0) ? 4'b0001 : 4'b1000;
      n_checks++; if (gnt4 !== exp_g) begin n_fail++; $display("[TB] FAIL alt_gnt[%0d] got %b want %b", i, gnt4, exp_g); end
    end
    req4 = '0;
    tick();
    n_checks++; if (gnt4 !== 4'b0000) begin n_fail++; $display("[TB] FAIL alt_idle got %b want 0000", gnt4); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] exp_r;
    req4 = 4'b0001;
    #2;
    rst_n4 = 1'b0;
    tick();
    n_checks++; if (gnt4 !== 4'b0000) begin n_fail++; $display("[TB] FAIL abort_gnt got %b want 0000", gnt4); end
    n_checks++; if (rnd4 !== 8'h00) begin n_fail++; $display("[TB] FAIL abort_rnd got %h want 00", rnd4); end
    rst_n4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (busy4 !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_busy[%0d] got %b want 1", i, busy4); end
      n_checks++; if (gnt4 !== 4'b0000) begin n_fail++; $display("[TB] FAIL abort_warm_gnt[%0d] got %b want 0000", i, gnt4); end
      n_checks++; if (rnd4 !== 8'h00) begin n_fail++; $display("[TB] FAIL abort_warm_rnd[%0d] got %h want 00", i, rnd4); end
      tick();
    end
    n_checks++; if (gnt4 !== 4'b0000) begin n_fail++; $display("[TB] FAIL abort_serve_gnt got %b want 0000", gnt4); end
    tick();
    exp_r = model_perm(model_warm(0, 4));
    n_checks++; if (gnt4 !== 4'b0001) begin n_fail++; $display("[TB] FAIL abort_first_gnt got %b want 0001", gnt4); end
    n_checks++; if (rnd4 !== exp_r) begin n_fail++; $display("[TB] FAIL abort_first_rnd got %h want %h", rnd4, exp_r); end
    req4 = '0;
    tick();
  endtask

  task automatic test_random();
    int           s, warm, last, j;
    logic [N-1:0] r, exp_g;
    logic [7:0]   exp_r;
    logic         sv, found;
    logic [15:0]  sd;
    rst_n4 = 1'b0;
    tick();
    rst_n4 = 1'b1;
    s = 0; warm = 4; last = N - 1; exp_r = 8'h00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      r  = 4'($urandom_range(0, 15));
      sv = ($urandom_range(0, 15) == 0);
      sd = 16'($urandom);
      n_checks++; if (busy4 !== (warm > 0)) begin n_fail++; $display("[TB] FAIL rand_busy[%0d] got %b want %b", cyc, busy4, (warm > 0)); end
      req4 = r; seed_valid4 = sv; seed4 = sd;
      exp_g = '0;
      if (sv) begin
        s = int'(sd); warm = 4;
      end else if (warm > 0) begin
        s = model_next(s); warm--;
      end else if (r != '0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          j = (last + k) % N;
          if (!found && r[j]) begin
            found = 1'b1;
            exp_g = 4'b0001 << j;
            exp_r = model_perm(s);
            s     = model_next(s);
            last  = j;
          end
        end
      end
      tick();
      n_checks++; if ($countones(gnt4) > 1) begin n_fail++; $display("[TB] FAIL rand_onehot[%0d] got %b want at most one bit", cyc, gnt4); end
      n_checks++; if (gnt4 !== exp_g) begin n_fail++; $display("[TB] FAIL rand_gnt[%0d] got %b want %b", cyc, gnt4, exp_g); end
      n_checks++; if (rnd4 !== exp_r) begin n_fail++; $display("[TB] FAIL rand_rnd[%0d] got %h want %h", cyc, rnd4, exp_r); end
    end
    req4 = '0; seed_valid4 = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_no_warmup();
    test_seed();
    test_warmup_order();
    test_alternate();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
